// File: rtl/learn_sweep_seq.sv
// learn_sweep_seq: DDS learn-mode sweep that steps the controller frequency and stores ADC peak-to-peak per point
module learn_sweep_seq #(
  parameter int N_POINTS   = 100,
  parameter int SETTLE_CYC = 500000,
  parameter int MEAS_CYC   = 1000000,
  parameter int PULSE_CYC  = 4,
  parameter int ADC_W      = 12,
  parameter int ADDR_W     = 7
) (
  input  logic              clk_50m,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADC_W-1:0]  adc_data,
  input  logic              adc_valid,
  output logic              learn_en,
  output logic              next_freq,
  output logic              amp_wr_en,
  output logic [ADDR_W-1:0] amp_wr_addr,
  output logic [ADC_W-1:0]  amp_wr_data,
  output logic              busy,
  output logic              done
);
  typedef enum logic [2:0] {IDLE, SETTLE, MEAS, STORE, STEP, DONE} state_t;
  state_t state, state_n;
  logic start_d;
  logic [31:0] cnt;
  logic [ADDR_W-1:0] idx;
  logic [ADC_W-1:0] mn, mx;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = (start && !start_d) ? SETTLE : IDLE;
      SETTLE:  state_n = (cnt == 32'(SETTLE_CYC - 1)) ? MEAS : SETTLE;
      MEAS:    state_n = (cnt == 32'(MEAS_CYC - 1)) ? STORE : MEAS;
      STORE:   state_n = (idx == ADDR_W'(N_POINTS - 1)) ? DONE : STEP;
      STEP:    state_n = (cnt == 32'(PULSE_CYC - 1)) ? SETTLE : STEP;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (abort) state_n = IDLE;
    busy        = state != IDLE;
    learn_en    = busy;
    next_freq   = state == STEP && !abort;
    amp_wr_en   = state == STORE && !abort;
    done        = state == DONE && !abort;
    amp_wr_addr = amp_wr_en ? idx : '0;
    amp_wr_data = (amp_wr_en && mx >= mn) ? mx - mn : '0;
  end
  always_ff @(posedge clk_50m or negedge rst_n)
    if (!rst_n) begin
      state   <= IDLE;
      start_d <= 1'b1;
      cnt     <= '0;
      idx     <= '0;
      mn      <= '0;
      mx      <= '0;
    end else begin
      state   <= state_n;
      start_d <= start;
      cnt     <= (state_n != state) ? '0 : cnt + 32'd1;
      idx     <= (state == IDLE) ? '0 : (state == STEP && state_n == SETTLE) ? idx + ADDR_W'(1) : idx;
      mn      <= (state != MEAS && state_n == MEAS) ? '1 : (state == MEAS && adc_valid && adc_data < mn) ? adc_data : mn;
      mx      <= (state != MEAS && state_n == MEAS) ? '0 : (state == MEAS && adc_valid && adc_data > mx) ? adc_data : mx;
    end
endmodule
